// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: bubble encoding, fetch FSM states, response buffer depth.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry 32-bit response buffer between the instruction memory and the IF/DEC latch.
module fetch_fifo2
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head,
  output logic        full,
  output logic        empty
);

  logic [31:0] mem [FIFO_DEPTH];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        do_push;
  logic        do_pop;

  assign full    = (count == 2'(FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_pop  = pop & ~empty;
  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: pipelined IMEM requests, response buffering and the IF/DEC latch.
// Optional macro FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_ena,
  input  logic        fetch_nop,
  input  logic        flush_pipeline,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        misalign_err
);

  fetch_state_e state;
  logic [31:0]  req_pc;
  logic [31:0]  dlv_pc;
  logic [31:0]  target;
  logic [31:0]  fifo_head;
  logic [1:0]   outstanding;
  logic [1:0]   discard;
  logic [1:0]   out_nxt;
  logic [1:0]   fifo_occ;
  logic         accept;
  logic         resp;
  logic         drop;
  logic         keep;
  logic         bypass;
  logic         push;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic         target_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target     = branch_target;
  assign target_bad = |branch_target[1:0];
`else
  logic unused_target_lsb;
  assign unused_target_lsb = ^branch_target[1:0];
  assign target            = {branch_target[31:2], 2'b00};
  assign target_bad        = 1'b0;
`endif

  assign accept   = imem_req & imem_ready;
  assign resp     = imem_valid & (outstanding != 2'd0);
  assign drop     = resp & (discard != 2'd0);
  assign keep     = resp & ~drop & ~flush_pipeline;
  assign bypass   = keep & fifo_empty & fetch_ena & ~fetch_nop;
  assign push     = keep & ~bypass;
  assign pop      = ~flush_pipeline & ~fetch_nop & fetch_ena & ~fifo_empty;
  assign out_nxt  = outstanding + {1'b0, accept} - {1'b0, resp};
  assign fifo_occ = {fifo_full, ~fifo_full & ~fifo_empty};

  // Request credit covers both in-flight reads and buffered words, so the buffer never overflows.
  assign imem_req  = (state == ST_RUN) &&
                     ((3'(outstanding) + 3'(fifo_occ)) < 3'(FIFO_DEPTH));
  assign imem_addr = req_pc;

  fetch_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush_pipeline),
    .push      (push),
    .push_data (imem_rdata),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_BOOT;
      req_pc       <= RESET_PC;
      dlv_pc       <= RESET_PC;
      outstanding  <= '0;
      discard      <= '0;
      instr_out    <= NOP_INSTR;
      pc_out       <= RESET_PC;
      valid_out    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      if (accept) req_pc <= req_pc + 32'd4;
      if (flush_pipeline) begin
        // A request accepted in the flush cycle belongs to the old path, so it is counted as discard.
        req_pc       <= target;
        dlv_pc       <= target;
        discard      <= out_nxt;
        misalign_err <= target_bad;
        instr_out    <= NOP_INSTR;
        valid_out    <= 1'b0;
        state        <= ((out_nxt != 2'd0) || target_bad) ? ST_DRAIN : ST_RUN;
      end else begin
        if (drop) discard <= discard - 2'd1;
        case (state)
          ST_BOOT:  state <= ST_RUN;
          ST_DRAIN: if (drop && (discard == 2'd1) && !misalign_err) state <= ST_RUN;
          default:  ;
        endcase
        if (fetch_nop) begin
          instr_out <= NOP_INSTR;
          valid_out <= 1'b0;
        end else if (fetch_ena) begin
          if (pop || bypass) begin
            instr_out <= pop ? fifo_head : imem_rdata;
            valid_out <= 1'b1;
            pc_out    <= dlv_pc;
            dlv_pc    <= dlv_pc + 32'd4;
          end else begin
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle-exact vector table, corner sequences and a randomized scoreboard phase.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_ena;
  logic        fetch_nop;
  logic        flush_pipeline;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        misalign_err;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_ena      (fetch_ena),
    .fetch_nop      (fetch_nop),
    .flush_pipeline (flush_pipeline),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ena, nop, flush, rdy;
    logic [31:0] tgt;
    int unsigned lat;
    logic        chk, exp_valid;
    logic [31:0] exp_pc;
    logic        chk_req, exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct { int unsigned due; logic [31:0] data; } mem_rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mem_rsp_t    mem_q[$];
  exp_t        sb[$];
  vec_t        tbl[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int unsigned lat   = 1;
  logic [31:0] exp_req_pc;
  logic        m_valid;
  logic [31:0] m_pc, m_instr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic vec_t mk(input logic ena, nop, flush, input logic [31:0] tgt,
                              input logic rdy, input int unsigned l,
                              input logic chk, ev, input logic [31:0] epc,
                              input logic creq, ereq, input logic [31:0] eaddr);
    vec_t v;
    v.ena = ena; v.nop = nop; v.flush = flush; v.tgt = tgt; v.rdy = rdy; v.lat = l;
    v.chk = chk; v.exp_valid = ev; v.exp_pc = epc;
    v.chk_req = creq; v.exp_req = ereq; v.exp_addr = eaddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at the falling edge, then compare after the next falling edge.
  task automatic step(input vec_t v);
    mem_rsp_t r;
    exp_t     e;
    if (v.chk_req) begin
      check("imem_req", 32'(imem_req), 32'(v.exp_req));
      if (v.exp_req) check("imem_addr", imem_addr, v.exp_addr);
    end
    lat            = v.lat;
    fetch_ena      = v.ena;
    fetch_nop      = v.nop;
    flush_pipeline = v.flush;
    branch_target  = v.tgt;
    imem_ready     = v.rdy;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      imem_valid = 1'b1;
      imem_rdata = r.data;
    end else begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
    end
    if (imem_req && v.rdy) begin
      check("req_addr", imem_addr, exp_req_pc);
      r.due  = cyc + lat;
      r.data = mdata(imem_addr);
      mem_q.push_back(r);
      e.pc    = exp_req_pc;
      e.instr = mdata(exp_req_pc);
      sb.push_back(e);
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (v.flush) begin
      sb.delete();
      exp_req_pc = align(v.tgt);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (v.flush || v.nop) begin
      m_valid = 1'b0;
      m_instr = NOP;
      check("bubble_valid", 32'(valid_out), 32'd0);
    end else if (!v.ena) begin
      check("hold_valid", 32'(valid_out), 32'(m_valid));
    end else if (valid_out) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: actual pc_out=%h required no delivery (cycle %0d)", pc_out, cyc);
        m_valid = 1'b0;
        m_instr = NOP;
      end else begin
        e = sb.pop_front();
        m_valid = 1'b1;
        m_pc    = e.pc;
        m_instr = e.instr;
      end
    end else begin
      m_valid = 1'b0;
      m_instr = NOP;
    end
    check("instr_out", instr_out, m_instr);
    if (m_valid) check("pc_out", pc_out, m_pc);
    if (v.chk) begin
      check("tbl_valid", 32'(valid_out), 32'(v.exp_valid));
      if (v.exp_valid) check("tbl_pc", pc_out, v.exp_pc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_ena = 1'b0; fetch_nop = 1'b0; flush_pipeline = 1'b0; branch_target = '0;
    imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    mem_q.delete();
    sb.delete();
    exp_req_pc = 32'h0;
    m_valid = 1'b0; m_pc = 32'h0; m_instr = NOP;
    repeat (3) @(negedge clk);
    check("rst_instr", instr_out, NOP);
    check("rst_pc", pc_out, 32'h0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    rst_n = 1'b1;
    cyc = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //                ena nop fl  tgt       rdy lat chk ev  pc        creq req addr
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   1, 1, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 1, 32'h0,   1, 1, 32'h4));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 1, 32'h4,   1, 1, 32'h8));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h4,   1, 1, 32'hC));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h4,   1, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h4,   1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 1, 32'h8,   1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,   0, 1, 1, 1, 32'hC,   1, 1, 32'h10));
    tbl.push_back(mk(1, 0, 0, 32'h0,   0, 1, 1, 0, 32'h0,   1, 1, 32'h10));
    tbl.push_back(mk(1, 0, 0, 32'h0,   0, 1, 1, 0, 32'h0,   1, 1, 32'h10));
    tbl.push_back(mk(1, 0, 0, 32'h0,   0, 1, 1, 0, 32'h0,   1, 1, 32'h10));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   1, 1, 32'h10));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 1, 32'h10,  1, 1, 32'h14));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 1, 32'h14,  1, 1, 32'h18));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 3, 1, 1, 32'h18,  1, 1, 32'h1C));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 3, 1, 0, 32'h0,   1, 1, 32'h20));
    tbl.push_back(mk(1, 0, 1, 32'h100, 1, 3, 1, 0, 32'h0,   1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 3, 1, 0, 32'h0,   1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 3, 1, 0, 32'h0,   1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   1, 1, 32'h100));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 1, 32'h100, 1, 1, 32'h104));
    tbl.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 1, 32'h104, 1, 1, 32'h108));

    do_reset();
    foreach (tbl[i]) step(tbl[i]);

    // Flush together with a stall, while a response lands and a new request is accepted.
    step(mk(0, 0, 1, 32'h200, 1, 1, 1, 0, 32'h0,   1, 1, 32'h10C));
    step(mk(1, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   1, 0, 32'h0));
    step(mk(1, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   1, 1, 32'h200));
    step(mk(1, 0, 0, 32'h0,   1, 1, 1, 1, 32'h200, 1, 1, 32'h204));

    // Misaligned redirect.
    step(mk(1, 0, 1, 32'h102, 1, 1, 1, 0, 32'h0,   1, 1, 32'h208));
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_set", 32'(misalign_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(mk(1, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 1, 0, 32'h0));
      check("misalign_sticky", 32'(misalign_err), 32'd1);
    end
    check("misalign_noreq", 32'(imem_req), 32'd0);
    step(mk(1, 0, 1, 32'h300, 1, 1, 1, 0, 32'h0,   1, 0, 32'h0));
    check("misalign_clear", 32'(misalign_err), 32'd0);
    step(mk(1, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   1, 1, 32'h300));
    step(mk(1, 0, 0, 32'h0,   1, 1, 1, 1, 32'h300, 1, 1, 32'h304));
`else
    check("misalign_tied", 32'(misalign_err), 32'd0);
    step(mk(1, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   1, 0, 32'h0));
    step(mk(1, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   1, 1, 32'h100));
    step(mk(1, 0, 0, 32'h0,   1, 1, 1, 1, 32'h100, 1, 1, 32'h104));
    check("misalign_tied", 32'(misalign_err), 32'd0);
`endif

    // Randomized traffic, including redirects near the top of the address space.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 1023)) << 2);
      step(mk($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, t,
              $urandom_range(0, 3) != 0, $urandom_range(1, 3),
              0, 0, 32'h0, 0, 0, 32'h0));
    end
    for (int i = 0; i < 12; i++) step(mk(1, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 0, 32'h0));
    check("sb_drain", 32'(sb.size()), 32'd0);

    // Reset in the middle of traffic, then a clean restart from RESET_PC.
    for (int i = 0; i < 3; i++) step(mk(1, 0, 0, 32'h0, 1, 2, 0, 0, 32'h0, 0, 0, 32'h0));
    do_reset();
    for (int i = 0; i < 5; i++) step(tbl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
